fetch: RTL and testbench

//  Instruction fetch stage feeding decode. Holds the PC and issues word reads to instruction memory

---
 rtl/fetch.sv | 180 ++++++++++++++++++
 tb/tb_fetch.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch.sv
// Instruction fetch stage: holds the PC, issues credit-limited imem reads, buffers in-order
// responses for decode and flushes on redirect. Define FETCH_MISALIGN_CHECK_EN to add o_misaligned.
module fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        clk_en,
    input  logic        rst,
    output logic        o_imem_req_valid,
    input  logic        i_imem_req_ready,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_rsp_valid,
    input  logic [31:0] i_imem_rsp_data,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic [31:0] o_instruction,
    output logic [31:0] o_pc,
    output logic        o_valid,
`ifdef FETCH_MISALIGN_CHECK_EN
    output logic        o_misaligned,
`endif
    input  logic        i_ready
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam logic [CW:0] DEPTH_LIM = (CW + 1)'(FIFO_DEPTH);

    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] drop_q, drop_d;

    logic [31:0]   fifo_instr_q [FIFO_DEPTH];
    logic [31:0]   fifo_pc_q    [FIFO_DEPTH];
    logic [AW-1:0] fifo_wr_q, fifo_wr_d;
    logic [AW-1:0] fifo_rd_q, fifo_rd_d;
    logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;

    logic [31:0]   pcq_q [FIFO_DEPTH];
    logic [AW-1:0] pcq_wr_q, pcq_wr_d;
    logic [AW-1:0] pcq_rd_q, pcq_rd_d;

    logic [31:0]   redirect_target;
    logic          inhibit;
    logic [CW:0]   in_use;
    logic          credit;
    logic          req_fire;
    logic          rsp_fire;
    logic          push;
    logic          pop;
    logic          fifo_empty;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic misal_q, misal_d;

    assign redirect_target = i_redirect_pc;
    assign inhibit         = misal_q;
    assign o_misaligned    = misal_q;
`else
    logic unused_redirect_lsbs;

    assign redirect_target      = {i_redirect_pc[31:2], 2'b00};
    assign inhibit              = 1'b0;
    assign unused_redirect_lsbs = ^i_redirect_pc[1:0];
`endif

    // Old-path responses still in flight count against credit, so new requests wait for them.
    assign in_use     = {1'b0, outst_q} + {1'b0, fifo_cnt_q};
    assign credit     = (in_use < DEPTH_LIM);
    assign fifo_empty = (fifo_cnt_q == '0);

    assign o_imem_req_valid = !rst && !i_redirect && credit && (drop_q == '0) && !inhibit;
    assign o_imem_addr      = pc_q;

    assign req_fire = o_imem_req_valid && i_imem_req_ready && clk_en;
    assign rsp_fire = !rst && i_imem_rsp_valid && clk_en;
    assign push     = rsp_fire && (drop_q == '0) && !i_redirect;
    assign pop      = !rst && !fifo_empty && i_ready && clk_en;

    always_comb begin
        o_valid       = !fifo_empty;
        o_instruction = '0;
        o_pc          = '0;
        if (!fifo_empty) begin
            o_instruction = fifo_instr_q[fifo_rd_q];
            o_pc          = fifo_pc_q[fifo_rd_q];
        end
`ifdef FETCH_MISALIGN_CHECK_EN
        if (misal_q) begin
            o_pc = pc_q;
        end
`endif
    end

    always_comb begin
        pc_d       = pc_q;
        outst_d    = outst_q;
        drop_d     = drop_q;
        fifo_wr_d  = fifo_wr_q;
        fifo_rd_d  = fifo_rd_q;
        fifo_cnt_d = fifo_cnt_q;
        pcq_wr_d   = pcq_wr_q;
        pcq_rd_d   = pcq_rd_q;
`ifdef FETCH_MISALIGN_CHECK_EN
        misal_d    = misal_q;
`endif
        if (clk_en) begin
            if (req_fire) begin
                pc_d     = pc_q + 32'd4;
                pcq_wr_d = pcq_wr_q + AW'(1);
            end
            if (push) begin
                pcq_rd_d  = pcq_rd_q + AW'(1);
                fifo_wr_d = fifo_wr_q + AW'(1);
            end
            if (pop) begin
                fifo_rd_d = fifo_rd_q + AW'(1);
            end
            fifo_cnt_d = fifo_cnt_q + CW'(push) - CW'(pop);
            outst_d    = outst_q + CW'(req_fire) - CW'(rsp_fire);
            if (rsp_fire && (drop_q != '0)) begin
                drop_d = drop_q - CW'(1);
            end
            // Every request still in flight after this edge belongs to the old path.
            if (i_redirect) begin
                pc_d       = redirect_target;
                drop_d     = outst_q - CW'(i_imem_rsp_valid);
                fifo_wr_d  = '0;
                fifo_rd_d  = '0;
                fifo_cnt_d = '0;
                pcq_wr_d   = '0;
                pcq_rd_d   = '0;
`ifdef FETCH_MISALIGN_CHECK_EN
                misal_d    = (i_redirect_pc[1:0] != 2'b00);
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            outst_q    <= '0;
            drop_q     <= '0;
            fifo_wr_q  <= '0;
            fifo_rd_q  <= '0;
            fifo_cnt_q <= '0;
            pcq_wr_q   <= '0;
            pcq_rd_q   <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
            misal_q    <= 1'b0;
`endif
        end else begin
            pc_q       <= pc_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            fifo_wr_q  <= fifo_wr_d;
            fifo_rd_q  <= fifo_rd_d;
            fifo_cnt_q <= fifo_cnt_d;
            pcq_wr_q   <= pcq_wr_d;
            pcq_rd_q   <= pcq_rd_d;
`ifdef FETCH_MISALIGN_CHECK_EN
            misal_q    <= misal_d;
`endif
        end
    end

    // Payload storage needs no reset; occupancy is tracked by the pointers above.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            pcq_q[pcq_wr_q] <= pc_q;
        end
        if (push) begin
            fifo_instr_q[fifo_wr_q] <= i_imem_rsp_data;
            fifo_pc_q[fifo_wr_q]    <= pcq_q[pcq_rd_q];
        end
    end

endmodule

// File: tb/tb_fetch.sv
// Scoreboard bench for fetch: a behavioural imem with programmable latency, expected PCs queued
// by the stimulus and popped by an independent decode-side monitor.
module tb_fetch;

    logic        clk = 1'b0;
    logic        clk_en;
    logic        rst;
    logic        o_imem_req_valid;
    logic        i_imem_req_ready;
    logic [31:0] o_imem_addr;
    logic        i_imem_rsp_valid;
    logic [31:0] i_imem_rsp_data;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic [31:0] o_instruction;
    logic [31:0] o_pc;
    logic        o_valid;
    logic        i_ready;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        o_misaligned;
`endif

    fetch dut (
        .clk              (clk),
        .clk_en           (clk_en),
        .rst              (rst),
        .o_imem_req_valid (o_imem_req_valid),
        .i_imem_req_ready (i_imem_req_ready),
        .o_imem_addr      (o_imem_addr),
        .i_imem_rsp_valid (i_imem_rsp_valid),
        .i_imem_rsp_data  (i_imem_rsp_data),
        .i_redirect       (i_redirect),
        .i_redirect_pc    (i_redirect_pc),
        .o_instruction    (o_instruction),
        .o_pc             (o_pc),
        .o_valid          (o_valid),
`ifdef FETCH_MISALIGN_CHECK_EN
        .o_misaligned     (o_misaligned),
`endif
        .i_ready          (i_ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       mem_q[$];
    int          mem_lat = 1;
    logic [31:0] exp_q[$];
    int          acc_cyc_q[$];
    logic [31:0] next_pc = 32'h0;
    int          n_checks = 0;
    int          n_pass = 0;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic ok, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, req, $time);
    endtask

    task automatic push_stream(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(4 * i));
        next_pc = base + 32'(4 * n);
    endtask

    // Called in the posedge+1 phase; returns in the same phase.
    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, "_drain"}, exp_q.size() == 0, 32'(exp_q.size()), 32'h0);
        exp_q.delete();
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_o_valid"}, o_valid === 1'b0, 32'(o_valid), 32'h0);
        chk({name, "_req_valid"}, o_imem_req_valid === 1'b0, 32'(o_imem_req_valid), 32'h0);
        chk({name, "_o_pc"}, o_pc === 32'h0, o_pc, 32'h0);
        chk({name, "_o_instr"}, o_instruction === 32'h0, o_instruction, 32'h0);
    endtask

    // Instruction memory: in-order responses, mem_lat cycles after accept.
    initial begin
        mreq_t r;
        i_imem_rsp_valid = 1'b0;
        i_imem_rsp_data  = 32'h0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mem_q.delete();
            end else if (clk_en) begin
                if (i_imem_rsp_valid && mem_q.size() > 0) r = mem_q.pop_front();
                if (o_imem_req_valid && i_imem_req_ready) begin
                    r.addr = o_imem_addr;
                    r.due  = cyc + mem_lat;
                    mem_q.push_back(r);
                end
            end
            @(posedge clk); #1;
            if (mem_q.size() > 0 && cyc >= mem_q[0].due) begin
                i_imem_rsp_valid = 1'b1;
                i_imem_rsp_data  = word_at(mem_q[0].addr);
            end else begin
                i_imem_rsp_valid = 1'b0;
                i_imem_rsp_data  = 32'h0;
            end
        end
    end

    // Decode-side monitor; words handed over in a redirect cycle are wrong-path and ignored.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (!rst && clk_en && o_valid && i_ready && !i_redirect) begin
                acc_cyc_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_word: got pc 0x%08h, expected no word", o_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("word_pc", o_pc === e, o_pc, e);
                    chk("word_instr", o_instruction === word_at(e), o_instruction, word_at(e));
                end
            end
        end
    end

    initial begin
        logic [31:0] held;
        logic        stable;
        int          span;
        int          n;

        rst = 1'b1; clk_en = 1'b1; i_ready = 1'b0; i_imem_req_ready = 1'b1;
        i_redirect = 1'b0; i_redirect_pc = 32'h0;

        // Reset state, then test 1: straight-line stream from RESET_PC.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
        @(posedge clk); #1;
        acc_cyc_q.delete();
        push_stream(32'h0, 4);
        rst = 1'b0; i_ready = 1'b1;
        wait_drain("t1");
        span = -1;
        if (acc_cyc_q.size() >= 4) span = acc_cyc_q[3] - acc_cyc_q[0];
        chk("t1_count", acc_cyc_q.size() == 4, 32'(acc_cyc_q.size()), 32'd4);
        chk("t1_consecutive", span == 3, 32'(span), 32'd3);

        // Clock enable low freezes everything.
        push_stream(next_pc, 16);
        clk_en = 1'b0;
        @(negedge clk);
        held = o_pc;
        stable = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (o_pc !== held) stable = 1'b0;
        end
        chk("clken_pc_stable", stable, o_pc, held);
        @(posedge clk); #1;
        clk_en = 1'b1;

        // Test 2: decode stall fills the buffer and stops requests.
        repeat (3) begin @(posedge clk); #1; end
        i_ready = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("t2_req_stopped", o_imem_req_valid === 1'b0, 32'(o_imem_req_valid), 32'h0);
        chk("t2_o_valid", o_valid === 1'b1, 32'(o_valid), 32'h1);
        chk("t2_none_outstanding", mem_q.size() == 0, 32'(mem_q.size()), 32'h0);
        @(posedge clk); #1;
        i_ready = 1'b1;
        wait_drain("t2");

        // Test 4: memory back-pressure holds the address; buffer drains.
        push_stream(next_pc, 12);
        i_imem_req_ready = 1'b0;
        @(negedge clk);
        held = o_imem_addr;
        stable = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (o_imem_addr !== held) stable = 1'b0;
        end
        chk("t4_addr_held", stable, o_imem_addr, held);
        chk("t4_drained", o_valid === 1'b0, 32'(o_valid), 32'h0);
        chk("t4_req_pending", o_imem_req_valid === 1'b1, 32'(o_imem_req_valid), 32'h1);
        @(posedge clk); #1;
        i_imem_req_ready = 1'b1;
        @(negedge clk);
        chk("t4_resume_addr", o_imem_req_valid && (o_imem_addr === held), o_imem_addr, held);
        @(posedge clk); #1;
        wait_drain("t4");

        // Test 3: 3-cycle memory, redirect with two requests in flight.
        i_ready = 1'b0; i_imem_req_ready = 1'b0;
        i_redirect = 1'b1; i_redirect_pc = 32'h80;
        @(posedge clk); #1;
        i_redirect = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        mem_lat = 3;
        i_imem_req_ready = 1'b1;
        n = 0;
        while (mem_q.size() != 2 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("t3_two_in_flight", mem_q.size() == 2, 32'(mem_q.size()), 32'd2);
        i_redirect = 1'b1; i_redirect_pc = 32'h100;
        push_stream(32'h100, 4);
        @(negedge clk);
        chk("t3_no_req_on_redirect", o_imem_req_valid === 1'b0, 32'(o_imem_req_valid), 32'h0);
        @(posedge clk); #1;
        i_redirect = 1'b0; i_ready = 1'b1;
        wait_drain("t3");

        // Test 5: redirect coincident with a response and a decode pop.
        mem_lat = 1;
        i_redirect = 1'b1; i_redirect_pc = 32'h300;
        push_stream(32'h300, 6);
        @(posedge clk); #1;
        i_redirect = 1'b0;
        wait_drain("t5a");
        i_redirect = 1'b1; i_redirect_pc = 32'h400;
        push_stream(32'h400, 4);
        @(negedge clk);
        chk("t5_rsp_coincident", i_imem_rsp_valid === 1'b1, 32'(i_imem_rsp_valid), 32'h1);
        chk("t5_pop_coincident", o_valid === 1'b1, 32'(o_valid), 32'h1);
        chk("t5_no_req_on_redirect", o_imem_req_valid === 1'b0, 32'(o_imem_req_valid), 32'h0);
        @(posedge clk); #1;
        i_redirect = 1'b0;
        @(negedge clk);
        chk("t5_empty_after", o_valid === 1'b0, 32'(o_valid), 32'h0);
        chk("t5_empty_pc_zero", o_pc === 32'h0, o_pc, 32'h0);
        chk("t5_empty_instr_zero", o_instruction === 32'h0, o_instruction, 32'h0);
        @(posedge clk); #1;
        wait_drain("t5b");

        // PC wraps modulo 2^32.
        i_redirect = 1'b1; i_redirect_pc = 32'hFFFF_FFF8;
        push_stream(32'hFFFF_FFF8, 4);
        @(posedge clk); #1;
        i_redirect = 1'b0;
        wait_drain("wrap");

        // Test 6: misaligned redirect target.
        i_ready = 1'b0;
        i_redirect = 1'b1; i_redirect_pc = 32'h102;
`ifdef FETCH_MISALIGN_CHECK_EN
        @(posedge clk); #1;
        i_redirect = 1'b0;
        @(negedge clk);
        chk("t6_flag_set", o_misaligned === 1'b1, 32'(o_misaligned), 32'h1);
        chk("t6_pc_shown", o_pc === 32'h102, o_pc, 32'h102);
        chk("t6_o_valid", o_valid === 1'b0, 32'(o_valid), 32'h0);
        stable = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (o_imem_req_valid !== 1'b0) stable = 1'b0;
        end
        chk("t6_req_inhibited", stable, 32'(o_imem_req_valid), 32'h0);
        @(posedge clk); #1;
        i_redirect = 1'b1; i_redirect_pc = 32'h200; i_ready = 1'b1;
        push_stream(32'h200, 2);
        @(posedge clk); #1;
        i_redirect = 1'b0;
        @(negedge clk);
        chk("t6_flag_cleared", o_misaligned === 1'b0, 32'(o_misaligned), 32'h0);
        @(posedge clk); #1;
        wait_drain("t6");
`else
        push_stream(32'h100, 3);
        @(posedge clk); #1;
        i_redirect = 1'b0; i_ready = 1'b1;
        wait_drain("t6_aligned_down");
`endif

        // Mid-operation reset restarts from RESET_PC.
        i_ready = 1'b0; rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("midreset");
        @(posedge clk); #1;
        push_stream(32'h0, 4);
        rst = 1'b0; i_ready = 1'b1;
        wait_drain("midreset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
